koder64: RTL

//  Iterative 64-bit block encryptor (TEA, 128-bit key): the encrypt-side

---
 rtl/koder64.sv | 110 +++++++++++
 1 files changed

// File: rtl/koder64.sv
// Iterative TEA block encryptor: one full TEA cycle (both halves) per enabled clock.
// start/ena/rdy handshake mirrors dekoder64; res holds until the next block completes.
module koder64 #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         ena,
  input  logic [63:0]  data,
  input  logic [127:0] key,
  output logic [63:0]  res,
  output logic         rdy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = 64;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  v0, v1, sum, k0, k1, k2, k3;
  logic [W-1:0]  v0_nxt, v1_nxt, sum_nxt, k0_nxt, k1_nxt, k2_nxt, k3_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] res_nxt;
  logic          rdy_nxt;
  logic [W-1:0]  sum_rnd, v0_rnd, v1_rnd;

  // One TEA cycle; the v1 half uses the freshly updated v0.
  always_comb begin
    sum_rnd = sum + DELTA;
    v0_rnd  = v0 + (((v1 << 4) + k0) ^ (v1 + sum_rnd) ^ ((v1 >> 5) + k1));
    v1_rnd  = v1 + (((v0_rnd << 4) + k2) ^ (v0_rnd + sum_rnd) ^ ((v0_rnd >> 5) + k3));
  end

  always_comb begin
    state_nxt = state;
    v0_nxt    = v0;
    v1_nxt    = v1;
    sum_nxt   = sum;
    k0_nxt    = k0;
    k1_nxt    = k1;
    k2_nxt    = k2;
    k3_nxt    = k3;
    cnt_nxt   = cnt;
    res_nxt   = res;
    rdy_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          v0_nxt    = data[63:32];
          v1_nxt    = data[31:0];
          k0_nxt    = key[127:96];
          k1_nxt    = key[95:64];
          k2_nxt    = key[63:32];
          k3_nxt    = key[31:0];
          sum_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ena) begin
          v0_nxt  = v0_rnd;
          v1_nxt  = v1_rnd;
          sum_nxt = sum_rnd;
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) begin
            res_nxt   = {v0_rnd, v1_rnd};
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      k0    <= '0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
      cnt   <= '0;
      res   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      v0    <= v0_nxt;
      v1    <= v1_nxt;
      sum   <= sum_nxt;
      k0    <= k0_nxt;
      k1    <= k1_nxt;
      k2    <= k2_nxt;
      k3    <= k3_nxt;
      cnt   <= cnt_nxt;
      res   <= res_nxt;
      rdy   <= rdy_nxt;
    end
  end

endmodule
